// File: rtl/xil_srl_pkg.sv
// ---------------------------------------------------------------------------
// xil_srl_pkg
// Shared constants for SRLC32E-based buffers.
//   SRL_DEPTH : number of taps in one SRLC32E
//   SRL_AW    : width of the SRL dynamic read address
//   LVL_W     : width of occupancy counters (SRL count plus output register)
//   clog2()   : ceiling log2, kept here for cascaded (multi-SRL) variants
// ---------------------------------------------------------------------------
package xil_srl_pkg;

    localparam int SRL_DEPTH = 32'd32;
    localparam int SRL_AW    = 32'd5;
    localparam int LVL_W     = 32'd6;

    // Ceiling log2 of a positive value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'd0;
        v      = value - 32'd1;
        while (v > 32'd0) begin
            result = result + 32'd1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/srl_fifo_ctrl_srlc32e.sv
// ---------------------------------------------------------------------------
// SRLC32E
// Behavioural model of the Xilinx 32-deep addressable shift register.
//   CLK : shift clock (polarity selected by IS_CLK_INVERTED)
//   CE  : shift enable; D enters tap 0 and every tap moves up by one
//   D   : serial input
//   A   : dynamic read address, Q = tap[A]
//   Q   : addressed tap
//   Q31 : last tap, used for cascading
// The primitive has no reset; contents start at INIT.
// ---------------------------------------------------------------------------
module SRLC32E
    import xil_srl_pkg::*;
#(
    parameter logic [31:0] INIT            = 32'h0000_0000,
    parameter logic        IS_CLK_INVERTED = 1'b0
) (
    input  logic              CLK,
    input  logic              CE,
    input  logic              D,
    input  logic [SRL_AW-1:0] A,
    output logic              Q,
    output logic              Q31
);

    logic                 clk_s;
    logic [SRL_DEPTH-1:0] sr_r = INIT;

    assign clk_s = CLK ^ IS_CLK_INVERTED;

    // Shift register body: new bit enters at tap 0.
    always_ff @(posedge clk_s) begin
        if (CE) begin
            sr_r <= {sr_r[SRL_DEPTH-2:0], D};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign Q   = sr_r[A];
    assign Q31 = sr_r[SRL_DEPTH-1];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// srl_fifo_ctrl
// First-word-fall-through FIFO built from DATA_W SRLC32E shift registers
// (one per data bit) plus a registered output stage. Capacity is 33 words:
// 32 in the SRL bank and one in the output register.
//   CLK      : clock, rising edge
//   RST      : asynchronous reset, active-high
//   S_VALID  : write request
//   S_READY  : write accept (SRL bank not full)
//   S_DATA   : write data
//   S_AFULL  : LEVEL >= AFULL_THR
//   M_VALID  : output register holds valid data
//   M_READY  : downstream consumes M_DATA
//   M_DATA   : output register
//   LEVEL    : total occupancy 0..33 (SRL count + M_VALID)
// ---------------------------------------------------------------------------
module srl_fifo_ctrl
    import xil_srl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int AFULL_THR = 28
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [DATA_W-1:0] S_DATA,
    output logic              S_AFULL,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [DATA_W-1:0] M_DATA,
    output logic [LVL_W-1:0]  LEVEL
);

    localparam logic [LVL_W-1:0] CNT_FULL = LVL_W'(SRL_DEPTH);
    localparam logic [LVL_W-1:0] AFULL_LV = LVL_W'(AFULL_THR);

    logic [LVL_W-1:0]  cnt_r;
    logic              m_valid_r;
    logic [DATA_W-1:0] m_data_r;

    logic              s_ready_s;
    logic              push_s;
    logic              load_s;
    logic [SRL_AW-1:0] srl_addr_s;
    logic [DATA_W-1:0] srl_q_s;
    logic [DATA_W-1:0] q31_unused_s;
    logic [LVL_W-1:0]  level_s;

    // Ready depends on the stored count only. The shift enable is also
    // gated by RST so that no write lands during reset.
    assign s_ready_s = (cnt_r != CNT_FULL);
    assign push_s    = S_VALID & s_ready_s & ~RST;
    assign load_s    = (cnt_r != {LVL_W{1'b0}}) & (~m_valid_r | M_READY);

    // Oldest SRL entry sits at tap CNT-1; park the address at 0 when empty.
    always_comb begin
        srl_addr_s = {SRL_AW{1'b0}};
        if (cnt_r != {LVL_W{1'b0}}) begin
            srl_addr_s = SRL_AW'(cnt_r - {{(LVL_W-1){1'b0}}, 1'b1});
        end else begin
            srl_addr_s = {SRL_AW{1'b0}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_srl
            SRLC32E #(
                .INIT            (32'h0000_0000),
                .IS_CLK_INVERTED (1'b0)
            ) u_srl (
                .CLK (CLK),
                .CE  (push_s),
                .D   (S_DATA[gi]),
                .A   (srl_addr_s),
                .Q   (srl_q_s[gi]),
                .Q31 (q31_unused_s[gi])
            );
        end
    endgenerate

    // Count and output register. A simultaneous push and load leaves the
    // count unchanged: Q is sampled at the pre-shift address, so the word
    // taken is still the oldest one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r     <= {LVL_W{1'b0}};
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_W{1'b0}};
        end else begin
            if (load_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= srl_q_s;
            end else if (M_READY) begin
                m_valid_r <= 1'b0;
                m_data_r  <= m_data_r;
            end else begin
                m_valid_r <= m_valid_r;
                m_data_r  <= m_data_r;
            end

            case ({push_s, load_s})
                2'b10:   cnt_r <= cnt_r + {{(LVL_W-1){1'b0}}, 1'b1};
                2'b01:   cnt_r <= cnt_r - {{(LVL_W-1){1'b0}}, 1'b1};
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign level_s = cnt_r + {{(LVL_W-1){1'b0}}, m_valid_r};

    assign S_READY = s_ready_s;
    assign S_AFULL = (level_s >= AFULL_LV);
    assign M_VALID = m_valid_r;
    assign M_DATA  = m_data_r;
    assign LEVEL   = level_s;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_srl_fifo_ctrl
// Scoreboard bench for srl_fifo_ctrl (DATA_W=8, AFULL_THR=28). Accepted
// words are queued when driven and compared when the output register
// presents them; a small occupancy model predicts the flags.
// ---------------------------------------------------------------------------
module tb_srl_fifo_ctrl;

    logic       CLK;
    logic       RST;
    logic       S_VALID;
    logic       S_READY;
    logic [7:0] S_DATA;
    logic       S_AFULL;
    logic       M_VALID;
    logic       M_READY;
    logic [7:0] M_DATA;
    logic [5:0] LEVEL;

    int         checks;
    int         errors;
    int         mdl_cnt;
    logic       mdl_mv;
    logic [7:0] sb[$];

    srl_fifo_ctrl #(
        .DATA_W    (8),
        .AFULL_THR (28)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .S_VALID (S_VALID),
        .S_READY (S_READY),
        .S_DATA  (S_DATA),
        .S_AFULL (S_AFULL),
        .M_VALID (M_VALID),
        .M_READY (M_READY),
        .M_DATA  (M_DATA),
        .LEVEL   (LEVEL)
    );

    // 10 ns clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, check outputs against the model,
    // advance the model to the next rising edge.
    task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
        int   exp_level;
        logic exp_ready;
        logic push;
        logic load;
        @(negedge CLK);
        S_VALID = sv;
        S_DATA  = sd;
        M_READY = mr;
        #1;
        exp_level = mdl_cnt + (mdl_mv ? 1 : 0);
        exp_ready = (mdl_cnt != 32);
        chk("s_ready", {31'd0, S_READY}, {31'd0, exp_ready});
        chk("m_valid", {31'd0, M_VALID}, {31'd0, mdl_mv});
        chk("level", {26'd0, LEVEL}, exp_level);
        chk("s_afull", {31'd0, S_AFULL}, (exp_level >= 28) ? 32'd1 : 32'd0);
        if (mdl_mv && sb.size() > 0) begin
            chk("m_data", {24'd0, M_DATA}, {24'd0, sb[0]});
        end
        push = sv && exp_ready;
        load = (mdl_cnt != 0) && (!mdl_mv || mr);
        if (mdl_mv && mr && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        if (push) begin
            sb.push_back(sd);
        end
        if (load) begin
            mdl_mv = 1'b1;
        end else if (mr) begin
            mdl_mv = 1'b0;
        end
        mdl_cnt = mdl_cnt + (push ? 1 : 0) - (load ? 1 : 0);
        @(posedge CLK);
    endtask

    initial begin
        int pv;
        int pr;
        checks  = 0;
        errors  = 0;
        mdl_cnt = 0;
        mdl_mv  = 1'b0;
        RST     = 1'b1;
        S_VALID = 1'b0;
        S_DATA  = 8'h00;
        M_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_level", {26'd0, LEVEL}, 32'd0);
        chk("rst_mvalid", {31'd0, M_VALID}, 32'd0);
        chk("rst_sready", {31'd0, S_READY}, 32'd1);
        chk("rst_afull", {31'd0, S_AFULL}, 32'd0);
        chk("rst_mdata", {24'd0, M_DATA}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Latency: 0xA5 pushed into an empty FIFO shows after the second edge.
        step(1'b1, 8'hA5, 1'b1);
        #1;
        chk("lat_t", {31'd0, M_VALID}, 32'd0);
        step(1'b0, 8'h00, 1'b1);
        #1;
        chk("lat_t1_valid", {31'd0, M_VALID}, 32'd1);
        chk("lat_t1_data", {24'd0, M_DATA}, 32'hA5);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

        // Fill to 33 with the consumer stalled, then drain in order.
        for (int g = 0; g < 40 && sb.size() < 33; g++) begin
            step(1'b1, 8'(sb.size()), 1'b0);
        end
        #1;
        chk("fill_level", {26'd0, LEVEL}, 32'd33);
        chk("fill_sready", {31'd0, S_READY}, 32'd0);
        chk("fill_hold", {24'd0, M_DATA}, 32'h00);
        for (int i = 0; i < 33; i++) begin
            step(1'b0, 8'h00, 1'b1);
            #1;
            chk("drain_level", {26'd0, LEVEL}, 32'(32 - i));
        end
        step(1'b0, 8'h00, 1'b1);

        // Full with a simultaneous write and read: no write, then both.
        for (int g = 0; g < 40 && sb.size() < 33; g++) begin
            step(1'b1, 8'h40 + 8'(sb.size()), 1'b0);
        end
        step(1'b1, 8'h77, 1'b1);
        #1;
        chk("full_rd_level", {26'd0, LEVEL}, 32'd32);
        chk("full_rd_sready", {31'd0, S_READY}, 32'd1);
        step(1'b1, 8'h78, 1'b1);
        #1;
        chk("push_load_level", {26'd0, LEVEL}, 32'd32);
        for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset with ten words in the SRL bank.
        for (int g = 0; g < 20 && mdl_cnt < 10; g++) begin
            step(1'b1, 8'h90 + 8'(g), 1'b0);
        end
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_level", {26'd0, LEVEL}, 32'd0);
        chk("arst_mvalid", {31'd0, M_VALID}, 32'd0);
        chk("arst_sready", {31'd0, S_READY}, 32'd1);
        chk("arst_mdata", {24'd0, M_DATA}, 32'd0);
        sb.delete();
        mdl_cnt = 0;
        mdl_mv  = 1'b0;
        S_VALID = 1'b1;
        S_DATA  = 8'hEE;
        @(posedge CLK);
        #1;
        chk("rst_edge_level", {26'd0, LEVEL}, 32'd0);
        @(negedge CLK);
        RST     = 1'b0;
        S_VALID = 1'b0;
        step(1'b1, 8'h3C, 1'b1);
        step(1'b1, 8'h3D, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

        // Random streaming with phases that push towards full and empty.
        for (int ph = 0; ph < 10; ph++) begin
            pv = (ph % 2 == 0) ? 85 : 30;
            pr = (ph % 2 == 0) ? 30 : 85;
            if (ph >= 8) begin
                pv = 60;
                pr = 60;
            end
            for (int i = 0; i < 1000; i++) begin
                step(($urandom_range(99) < pv) ? 1'b1 : 1'b0,
                     8'($urandom_range(255)),
                     ($urandom_range(99) < pr) ? 1'b1 : 1'b0);
            end
        end
        for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
